// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - button sequencer for the countdown timer datapath
// Optional feature macro: TIMER_CTRL_ALARM_EN (ALARM state, alarm counter, alarm_o)
module timer_ctrl #(
   parameter int         ALARM_SECS = 10,
   parameter logic [3:0] EN_CODE    = 4'b0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        btn_mode,
   input  logic        btn_start,
   input  logic        btn_next,
   input  logic        btn_inc,
   input  logic [23:0] tm_i,
   output logic        swt_o,
   output logic [3:0]  en_o,
   output logic [2:0]  digit_o,
   output logic        ib_o,
   output logic        sb_o,
   output logic        alarm_o,
   output logic        blink_o
);

`ifdef TIMER_CTRL_ALARM_EN
   typedef enum logic [2:0] {S_IDLE, S_EDIT, S_RUN, S_PAUSE, S_ALARM} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_EDIT, S_RUN, S_PAUSE} state_t;
`endif

   state_t     state;
   state_t     next_state;
   logic [2:0] next_digit;
   logic       next_ib;
   logic       next_sb;
   logic       next_blink;

   // Only the highest-priority pressed button is acted on; the rest are dropped
   logic sel_mode;
   logic sel_start;
   logic sel_next;
   logic sel_inc;
   logic any_btn;
   logic tm_zero;

   assign sel_mode  = btn_mode;
   assign sel_start = btn_start & ~btn_mode;
   assign sel_next  = btn_next & ~btn_mode & ~btn_start;
   assign sel_inc   = btn_inc & ~btn_mode & ~btn_start & ~btn_next;
   assign any_btn   = btn_mode | btn_start | btn_next | btn_inc;
   assign tm_zero   = (tm_i == 24'd0);

`ifdef TIMER_CTRL_ALARM_EN
   logic [7:0] alarm_cnt;
   logic [7:0] next_cnt;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state, strobe and digit decode
   always_comb begin
      next_state = state;
      next_digit = digit_o;
      next_ib    = 1'b0;
      next_sb    = 1'b0;
`ifdef TIMER_CTRL_ALARM_EN
      next_cnt   = alarm_cnt;
`endif
      case (state)
         S_IDLE: begin
            if (sel_mode) begin
               next_state = S_EDIT;
               next_digit = 3'd1;
            end else if (sel_start && !tm_zero) begin
               next_state = S_RUN;
            end
         end
         S_EDIT: begin
            if (sel_mode) begin
               next_state = S_IDLE;
            end else if (sel_start) begin
               if (!tm_zero) begin
                  next_state = S_RUN;
               end
            end else if (sel_next) begin
               next_digit = (digit_o == 3'd6) ? 3'd1 : digit_o + 3'd1;
            end else if (sel_inc) begin
               next_ib = 1'b1;
            end
         end
         S_RUN: begin
            if (sel_mode) begin
               next_state = S_IDLE;
               next_sb    = 1'b1;
            end else if (sel_start) begin
               next_state = S_PAUSE;
            end else if (!any_btn && tm_zero) begin
`ifdef TIMER_CTRL_ALARM_EN
               next_state = S_ALARM;
               next_cnt   = 8'd0;
`else
               next_state = S_IDLE;
               next_sb    = 1'b1;
`endif
            end
         end
         S_PAUSE: begin
            if (sel_mode) begin
               next_state = S_IDLE;
               next_sb    = 1'b1;
            end else if (sel_start) begin
               next_state = S_RUN;
            end
         end
`ifdef TIMER_CTRL_ALARM_EN
         S_ALARM: begin
            // A button beats a coincident tick; either way there is a single exit strobe
            if (any_btn) begin
               next_state = S_IDLE;
               next_sb    = 1'b1;
            end else if (tick_1hz) begin
               if (alarm_cnt == 8'(ALARM_SECS - 1)) begin
                  next_state = S_IDLE;
                  next_sb    = 1'b1;
               end else begin
                  next_cnt = alarm_cnt + 8'd1;
               end
            end
         end
`endif
         default: begin
            next_state = S_IDLE;
         end
      endcase
      next_blink = (state == S_EDIT && next_state == S_EDIT) ? (blink_o ^ tick_1hz) : 1'b0;
   end

   // Registered outputs derived from the upcoming state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         swt_o   <= 1'b0;
         en_o    <= 4'b0000;
         digit_o <= 3'd1;
         ib_o    <= 1'b0;
         sb_o    <= 1'b0;
         blink_o <= 1'b0;
      end else begin
         swt_o   <= (next_state == S_RUN);
         en_o    <= (next_state == S_EDIT) ? EN_CODE : 4'b0000;
         digit_o <= next_digit;
         ib_o    <= next_ib;
         sb_o    <= next_sb;
         blink_o <= next_blink;
      end
   end

`ifdef TIMER_CTRL_ALARM_EN
   // Alarm duration counter and alarm output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_cnt <= 8'd0;
         alarm_o   <= 1'b0;
      end else begin
         alarm_cnt <= next_cnt;
         alarm_o   <= (next_state == S_ALARM);
      end
   end
`else
   assign alarm_o = 1'b0;
`endif

endmodule
